// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result requests and CDB broadcast bundle for cdb_arbiter
//
// Purpose: groups the per-FU request handshake and the single CDB broadcast
// port into one bundle so the arbiter and its FUs connect through a single port.
//
// Signals:
//   req_valid     [NUM_REQ]             FU i has a result waiting
//   req_ready     [NUM_REQ]             grant; FU i's result is accepted this cycle
//   req_rob_id    [NUM_REQ][ROB_IDX]    per-FU rob id
//   req_rd_phy    [NUM_REQ][PRF_IDX]    per-FU destination physical register
//   req_rd_arch   [NUM_REQ][ARF_IDX]    per-FU destination architectural register
//   req_rd_value  [NUM_REQ][32]         per-FU result value
//   cdb_valid                           broadcast valid
//   cdb_rob_id / cdb_rd_phy / cdb_rd_arch / cdb_rd_value   broadcast payload
//
// Modports:
//   master - FU side: drives requests, sees grants and the broadcast
//   slave  - arbiter side: sees requests, drives grants and the broadcast
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ROB_IDX = 6,
   parameter int PRF_IDX = 7,
   parameter int ARF_IDX = 5
);
   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ-1:0][ROB_IDX-1:0] req_rob_id;
   logic [NUM_REQ-1:0][PRF_IDX-1:0] req_rd_phy;
   logic [NUM_REQ-1:0][ARF_IDX-1:0] req_rd_arch;
   logic [NUM_REQ-1:0][31:0]        req_rd_value;

   logic                            cdb_valid;
   logic [ROB_IDX-1:0]              cdb_rob_id;
   logic [PRF_IDX-1:0]              cdb_rd_phy;
   logic [ARF_IDX-1:0]              cdb_rd_arch;
   logic [31:0]                     cdb_rd_value;

   modport master (
      output req_valid,
      output req_rob_id,
      output req_rd_phy,
      output req_rd_arch,
      output req_rd_value,
      input  req_ready,
      input  cdb_valid,
      input  cdb_rob_id,
      input  cdb_rd_phy,
      input  cdb_rd_arch,
      input  cdb_rd_value
   );

   modport slave (
      input  req_valid,
      input  req_rob_id,
      input  req_rd_phy,
      input  req_rd_arch,
      input  req_rd_value,
      output req_ready,
      output cdb_valid,
      output cdb_rob_id,
      output cdb_rd_phy,
      output cdb_rd_arch,
      output cdb_rd_value
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with priority requester, round-robin and starvation override
//
// Purpose: shares one CDB broadcast port among NUM_REQ functional units.
// One requester is granted per cycle; its result is registered and broadcast
// on the CDB the following cycle. Requester PRIO_REQ wins by default, the
// others rotate round-robin, and a low-priority requester that has lost
// STARVE_LIMIT consecutive cycles overrides PRIO_REQ.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   flush  in   mispredict flush; suppresses this cycle's grant and clears starvation state
//   bus    slave modport of cdb_arbiter_if (requests, grants, CDB broadcast)
module cdb_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int PRIO_REQ     = 0,
   parameter int STARVE_LIMIT = 4,
   parameter int ROB_IDX      = 6,
   parameter int PRF_IDX      = 7,
   parameter int ARF_IDX      = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   cdb_arbiter_if.slave  bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [IDX_W-1:0] PRIO_IDX = IDX_W'(PRIO_REQ);
   // First low-priority index in circular order starting from 0.
   localparam logic [IDX_W-1:0] RR_RESET = (PRIO_REQ == 0) ? IDX_W'(1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

   // Round-robin pointer and per-requester starvation counters
   logic [IDX_W-1:0] rr_ptr;
   logic [CNT_W-1:0] starve_cnt [NUM_REQ];

   // Scan results
   logic [IDX_W-1:0] scan_idx;
   logic             rr_hit;
   logic [IDX_W-1:0] rr_idx;
   logic             starve_hit;
   logic [IDX_W-1:0] starve_idx;

   // Final grant
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] rr_next;

   // Registered CDB broadcast
   logic               cdb_valid_q;
   logic [ROB_IDX-1:0] cdb_rob_id_q;
   logic [PRF_IDX-1:0] cdb_rd_phy_q;
   logic [ARF_IDX-1:0] cdb_rd_arch_q;
   logic [31:0]        cdb_rd_value_q;

   // (base + k) mod NUM_REQ; base < NUM_REQ and k <= NUM_REQ, so one
   // conditional subtract is enough.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= 32'(NUM_REQ)) begin
         s = s - 32'(NUM_REQ);
      end
      return s[IDX_W-1:0];
   endfunction

   // Circular scan from rr_ptr over the low-priority requesters. Two
   // independent "first hit" searches share the same walk: the first valid
   // requester and the first valid requester whose counter has saturated.
   always_comb begin
      scan_idx   = '0;
      rr_hit     = 1'b0;
      rr_idx     = '0;
      starve_hit = 1'b0;
      starve_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = wrap_add(rr_ptr, k);
         if (scan_idx != PRIO_IDX && bus.req_valid[scan_idx]) begin
            if (!rr_hit) begin
               rr_hit = 1'b1;
               rr_idx = scan_idx;
            end
            if (!starve_hit && starve_cnt[scan_idx] == CNT_MAX) begin
               starve_hit = 1'b1;
               starve_idx = scan_idx;
            end
         end
      end
   end

   // Grant selection: starved low-priority first, then PRIO_REQ, then
   // round-robin among the rest. Reset and flush suppress any grant, which
   // also keeps req_ready low while rst is asserted.
   always_comb begin
      gnt_valid     = 1'b0;
      gnt_idx       = '0;
      bus.req_ready = '0;
      if (starve_hit) begin
         gnt_valid = 1'b1;
         gnt_idx   = starve_idx;
      end else if (bus.req_valid[PRIO_REQ]) begin
         gnt_valid = 1'b1;
         gnt_idx   = PRIO_IDX;
      end else if (rr_hit) begin
         gnt_valid = 1'b1;
         gnt_idx   = rr_idx;
      end
      if (rst || flush) begin
         gnt_valid = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = gnt_valid && (gnt_idx == IDX_W'(i));
      end
   end

   // Next low-priority index after the current grant, stepping over PRIO_REQ.
   always_comb begin
      rr_next = wrap_add(gnt_idx, 1);
      if (rr_next == PRIO_IDX) begin
         rr_next = wrap_add(gnt_idx, 2);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid_q    <= 1'b0;
         cdb_rob_id_q   <= '0;
         cdb_rd_phy_q   <= '0;
         cdb_rd_arch_q  <= '0;
         cdb_rd_value_q <= '0;
         rr_ptr         <= RR_RESET;
         for (int i = 0; i < NUM_REQ; i++) begin
            starve_cnt[i] <= '0;
         end
      end else begin
         // gnt_valid is already low under flush, so the CDB goes idle next cycle.
         cdb_valid_q <= gnt_valid;
         if (gnt_valid) begin
            cdb_rob_id_q   <= bus.req_rob_id[gnt_idx];
            cdb_rd_phy_q   <= bus.req_rd_phy[gnt_idx];
            cdb_rd_arch_q  <= bus.req_rd_arch[gnt_idx];
            cdb_rd_value_q <= bus.req_rd_value[gnt_idx];
         end

         // Only low-priority wins advance the rotation.
         if (gnt_valid && gnt_idx != PRIO_IDX) begin
            rr_ptr <= rr_next;
         end

         // Counters track consecutive lost cycles while valid; PRIO_REQ's
         // entry is pinned at zero so it can never look starved.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (flush || i == PRIO_REQ || !bus.req_valid[i] || bus.req_ready[i]) begin
               starve_cnt[i] <= '0;
            end else if (starve_cnt[i] != CNT_MAX) begin
               starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign bus.cdb_valid    = cdb_valid_q;
   assign bus.cdb_rob_id   = cdb_rob_id_q;
   assign bus.cdb_rd_phy   = cdb_rd_phy_q;
   assign bus.cdb_rd_arch  = cdb_rd_arch_q;
   assign bus.cdb_rd_value = cdb_rd_value_q;

   a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(bus.req_ready));

   a_ready_implies_valid: assert property (@(posedge clk) disable iff (rst)
      (bus.req_ready & ~bus.req_valid) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard testbench for cdb_arbiter
module tb_cdb_arbiter;
   localparam int NUM_REQ = 3;
   localparam int ROB_IDX = 6;
   localparam int PRF_IDX = 7;
   localparam int ARF_IDX = 5;
   localparam int PW      = ROB_IDX + PRF_IDX + ARF_IDX + 32;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   cdb_arbiter_if #(
      .NUM_REQ (NUM_REQ),
      .ROB_IDX (ROB_IDX),
      .PRF_IDX (PRF_IDX),
      .ARF_IDX (ARF_IDX)
   ) bus ();

   cdb_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .PRIO_REQ     (0),
      .STARVE_LIMIT (4),
      .ROB_IDX      (ROB_IDX),
      .PRF_IDX      (PRF_IDX),
      .ARF_IDX      (ARF_IDX)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [PW-1:0] exp_q [$];

   logic [ROB_IDX-1:0] p_rob  [NUM_REQ];
   logic [PRF_IDX-1:0] p_phy  [NUM_REQ];
   logic [ARF_IDX-1:0] p_arch [NUM_REQ];
   logic [31:0]        p_val  [NUM_REQ];

   function automatic logic [PW-1:0] pack_fu(input int i);
      return {p_rob[i], p_phy[i], p_arch[i], p_val[i]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_cdb(input string name, input logic e);
      check(name, 64'(bus.cdb_valid), 64'(e));
   endtask

   // One arbitration cycle: apply inputs just after the edge, check the
   // combinational grant mid-cycle, and queue the expected broadcast.
   task automatic cycle(input string name, input logic rs, input logic [2:0] v,
                        input logic fl, input logic [2:0] exp_rdy);
      @(posedge clk);
      #1;
      rst   = rs;
      flush = fl;
      bus.req_valid = v;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_rob_id[i]   = p_rob[i];
         bus.req_rd_phy[i]   = p_phy[i];
         bus.req_rd_arch[i]  = p_arch[i];
         bus.req_rd_value[i] = p_val[i];
      end
      #2;
      check(name, 64'(bus.req_ready), 64'(exp_rdy));
      for (int i = 0; i < NUM_REQ; i++) begin
         if (exp_rdy[i]) begin
            exp_q.push_back(pack_fu(i));
            // Accepted: this FU presents a fresh result next time.
            p_val[i] = p_val[i] + 32'h11;
            p_rob[i] = p_rob[i] + 6'd1;
         end
      end
   endtask

   // Monitor: every broadcast must match the oldest queued grant.
   initial begin
      logic [PW-1:0] e;
      logic [PW-1:0] act;
      forever begin
         @(negedge clk);
         if (bus.cdb_valid === 1'b1) begin
            total++;
            act = {bus.cdb_rob_id, bus.cdb_rd_phy, bus.cdb_rd_arch, bus.cdb_rd_value};
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL cdb_unexpected: got %0h expected no broadcast", act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  bad++;
                  $display("FAIL cdb_payload: got %0h expected %0h", act, e);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1);
   end

   initial begin
      p_rob[0] = 6'd1;  p_phy[0] = 7'd10; p_arch[0] = 5'd1; p_val[0] = 32'hA000_0000;
      p_rob[1] = 6'd5;  p_phy[1] = 7'd17; p_arch[1] = 5'd3; p_val[1] = 32'hDEAD_BEEF;
      p_rob[2] = 6'd9;  p_phy[2] = 7'd30; p_arch[2] = 5'd7; p_val[2] = 32'hC000_0000;
      bus.req_valid    = '0;
      bus.req_rob_id   = '0;
      bus.req_rd_phy   = '0;
      bus.req_rd_arch  = '0;
      bus.req_rd_value = '0;

      // T1 reset with everyone requesting
      cycle("t1_rst_a", 1'b1, 3'b111, 1'b0, 3'b000);
      chk_cdb("t1_cdb_a", 1'b0);
      cycle("t1_rst_b", 1'b1, 3'b111, 1'b0, 3'b000);
      chk_cdb("t1_cdb_b", 1'b0);
      cycle("t1_first_grant", 1'b0, 3'b111, 1'b0, 3'b001);
      chk_cdb("t1_cdb_c", 1'b0);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);

      // T2 single requester latency
      cycle("t2_grant", 1'b0, 3'b010, 1'b0, 3'b010);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);
      chk_cdb("t2_cdb_t1", 1'b1);
      check("t2_rob_id", 64'(bus.cdb_rob_id), 64'd5);
      check("t2_rd_phy", 64'(bus.cdb_rd_phy), 64'd17);
      check("t2_value", 64'(bus.cdb_rd_value), 64'hDEAD_BEEF);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);
      chk_cdb("t2_cdb_t2", 1'b0);

      // Reset and flush together: reset wins, rr_ptr back to 1
      cycle("rst_flush", 1'b1, 3'b111, 1'b1, 3'b000);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);
      chk_cdb("rst_flush_cdb", 1'b0);

      // T3 round-robin among low-priority requesters
      cycle("t3_rr0", 1'b0, 3'b110, 1'b0, 3'b010);
      cycle("t3_rr1", 1'b0, 3'b110, 1'b0, 3'b100);
      cycle("t3_rr2", 1'b0, 3'b110, 1'b0, 3'b010);
      cycle("t3_rr3", 1'b0, 3'b110, 1'b0, 3'b100);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);

      // T4 starvation override after four lost cycles
      for (int k = 0; k < 4; k++) begin
         cycle($sformatf("t4_prio%0d", k), 1'b0, 3'b101, 1'b0, 3'b001);
      end
      cycle("t4_starved", 1'b0, 3'b101, 1'b0, 3'b100);
      cycle("t4_after", 1'b0, 3'b101, 1'b0, 3'b001);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);

      // T5 flush drops the grant and clears starvation history
      for (int k = 0; k < 3; k++) begin
         cycle($sformatf("t5_pre%0d", k), 1'b0, 3'b101, 1'b0, 3'b001);
      end
      cycle("t5_flush", 1'b0, 3'b101, 1'b1, 3'b000);
      cycle("t5_post0", 1'b0, 3'b101, 1'b0, 3'b001);
      chk_cdb("t5_cdb_after_flush", 1'b0);
      for (int k = 1; k < 4; k++) begin
         cycle($sformatf("t5_post%0d", k), 1'b0, 3'b101, 1'b0, 3'b001);
      end
      cycle("t5_starved", 1'b0, 3'b101, 1'b0, 3'b100);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);

      // T6 back-to-back results from the priority requester
      for (int k = 0; k < 8; k++) begin
         cycle($sformatf("t6_b2b%0d", k), 1'b0, 3'b001, 1'b0, 3'b001);
         if (k > 0) chk_cdb($sformatf("t6_cdb%0d", k), 1'b1);
      end
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);
      chk_cdb("t6_cdb_last", 1'b1);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);
      chk_cdb("t6_cdb_done", 1'b0);

      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);
      cycle("idle", 1'b0, 3'b000, 1'b0, 3'b000);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
